// File: rtl/pwm_update_scheduler.sv
// pwm_update_scheduler: arbitrates the PWM register-file bus between host accesses and a staged period/compare update engine.
// Ports: clk, rst_n (async active-low); host_* decoder bus in, host_rdata out; regs_* register-file bus;
// counter_val/cnt_en boundary sources; upd_* valid/ready update request; upd_done, busy, sync_timeout status.
// Macro UPD_COUNT_RESET_EN: when defined, each update ends with a write of 0x00 to addr 0x07 to restart the counter.
module pwm_update_scheduler #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_read,
  input  logic        host_write,
  input  logic [5:0]  host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        regs_read,
  output logic        regs_write,
  output logic [5:0]  regs_addr,
  output logic [7:0]  regs_wdata,
  input  logic [7:0]  regs_rdata,
  input  logic [15:0] counter_val,
  input  logic        cnt_en,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_period,
  input  logic [15:0] upd_cmp1,
  input  logic [15:0] upd_cmp2,
  input  logic [2:0]  upd_mask,
  input  logic        upd_sync,
  output logic        upd_done,
  output logic        busy,
  output logic        sync_timeout
);
  typedef enum logic [1:0] {IDLE, WAIT_SYNC, WRITE, DONE} state_t;
`ifdef UPD_COUNT_RESET_EN
  localparam logic CNT_RST = 1'b1;
`else
  localparam logic CNT_RST = 1'b0;
`endif
  state_t state, state_next;
  logic [6:0] pend, pend_next, pend_init, pend_left;
  logic [15:0] wcnt, wcnt_next, period, cmp1, cmp2;
  logic timeout_next, host, accept, boundary, expire, engine;
  logic [2:0] idx;
  logic [55:0] bytes;
  logic [5:0] byte_addr;
  logic [7:0] byte_data;
  // One pending bit per byte slot, low byte first; slot 6 is the optional counter restart.
  assign pend_init = {CNT_RST, upd_mask[2], upd_mask[2], upd_mask[1], upd_mask[1], upd_mask[0], upd_mask[0]};
  assign pend_left = pend & (pend - 7'd1);
  assign host = host_read | host_write;
  assign accept = upd_valid && state == IDLE;
  assign boundary = !cnt_en || counter_val == 16'h0000;
  assign expire = wcnt == 16'(TIMEOUT_CYCLES - 1);
  assign engine = state == WRITE;
  assign bytes = {8'h00, cmp2, cmp1, period};
  assign byte_addr = idx < 3'd2 ? {3'b000, idx} : {3'b000, idx} + 6'd1;
  assign byte_data = bytes[{idx, 3'b000} +: 8];
  assign host_rdata = regs_rdata;
  assign regs_read = host ? host_read : 1'b0;
  assign regs_write = host ? host_write : engine;
  assign regs_addr = host ? host_addr : engine ? byte_addr : 6'd0;
  assign regs_wdata = host ? host_wdata : engine ? byte_data : 8'd0;
  assign upd_ready = state == IDLE;
  assign upd_done = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    idx = 3'd0;
    for (int i = 6; i >= 0; i--) if (pend[i]) idx = 3'(i);
  end
  always_comb begin
    state_next = state;
    pend_next = pend;
    wcnt_next = wcnt;
    timeout_next = sync_timeout;
    case (state)
      IDLE: if (accept) begin
        pend_next = pend_init;
        wcnt_next = 16'd0;
        timeout_next = 1'b0;
        state_next = pend_init == 7'd0 ? DONE : (upd_sync && |upd_mask) ? WAIT_SYNC : WRITE;
      end
      WAIT_SYNC: begin
        wcnt_next = wcnt + 16'd1;
        state_next = (boundary || expire) ? WRITE : WAIT_SYNC;
        timeout_next = !boundary && expire ? 1'b1 : sync_timeout;
      end
      WRITE: if (!host) begin
        pend_next = pend_left;
        state_next = pend_left == 7'd0 ? DONE : WRITE;
      end
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend <= 7'd0;
      wcnt <= 16'd0;
      sync_timeout <= 1'b0;
      period <= 16'd0;
      cmp1 <= 16'd0;
      cmp2 <= 16'd0;
    end else begin
      state <= state_next;
      pend <= pend_next;
      wcnt <= wcnt_next;
      sync_timeout <= timeout_next;
      if (accept) begin
        period <= upd_period;
        cmp1 <= upd_cmp1;
        cmp2 <= upd_cmp2;
      end
    end
  end
endmodule

// File: tb/tb_pwm_update_scheduler.sv
// tb_pwm_update_scheduler: directed self-checking bench for pwm_update_scheduler (TIMEOUT_CYCLES=8).
module tb_pwm_update_scheduler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic host_read = 0, host_write = 0;
  logic [5:0] host_addr = 0;
  logic [7:0] host_wdata = 0, host_rdata, regs_wdata, regs_rdata = 0;
  logic regs_read, regs_write, upd_ready, upd_done, busy, sync_timeout;
  logic [5:0] regs_addr;
  logic [15:0] counter_val = 0, upd_period = 0, upd_cmp1 = 0, upd_cmp2 = 0;
  logic cnt_en = 0, upd_valid = 0, upd_sync = 0;
  logic [2:0] upd_mask = 0;
  int n = 0, fails = 0;
  always #5 clk = ~clk;
  pwm_update_scheduler #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .host_read(host_read), .host_write(host_write),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .regs_read(regs_read), .regs_write(regs_write), .regs_addr(regs_addr),
    .regs_wdata(regs_wdata), .regs_rdata(regs_rdata), .counter_val(counter_val),
    .cnt_en(cnt_en), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_period(upd_period), .upd_cmp1(upd_cmp1), .upd_cmp2(upd_cmp2),
    .upd_mask(upd_mask), .upd_sync(upd_sync), .upd_done(upd_done), .busy(busy),
    .sync_timeout(sync_timeout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_wr(input string tag, input logic [5:0] a, input logic [7:0] d);
    chk(tag, {17'd0, regs_write, regs_addr, regs_wdata}, {17'd0, 1'b1, a, d});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic request(input logic [15:0] p, input logic [15:0] c1, input logic [15:0] c2,
                         input logic [2:0] m, input logic s);
    upd_period = p; upd_cmp1 = c1; upd_cmp2 = c2; upd_mask = m; upd_sync = s; upd_valid = 1'b1;
    tick;
    upd_valid = 1'b0;
    #1;
  endtask
  task automatic finish_upd(input string tag);
`ifdef UPD_COUNT_RESET_EN
    tick;
    chk({tag, "_cnt_rst"}, {17'd0, regs_write, regs_addr, regs_wdata}, {17'd0, 1'b1, 6'h07, 8'h00});
`endif
    tick;
    chk({tag, "_done"}, {30'd0, upd_done, regs_write}, {30'd0, 1'b1, 1'b0});
    tick;
    chk({tag, "_idle"}, {29'd0, upd_done, busy, upd_ready}, {29'd0, 1'b0, 1'b0, 1'b1});
  endtask
  logic [5:0] full_a [6] = '{6'h00, 6'h01, 6'h03, 6'h04, 6'h05, 6'h06};
  logic [7:0] full_d [6] = '{8'h34, 8'h12, 8'h00, 8'h04, 8'h00, 8'h08};
  initial begin
    #2;
    chk("rst_status", {28'd0, upd_ready, upd_done, busy, sync_timeout}, {28'd0, 4'b1000});
    chk("rst_bus", {17'd0, regs_write, regs_addr, regs_wdata}, 32'd0);
    regs_rdata = 8'h5A;
    #1 chk("rdata_pass", {24'd0, host_rdata}, 32'h5A);
    tick;
    rst_n = 1'b1;
    tick;
    host_read = 1'b1; host_addr = 6'h2A;
    #1 chk("host_read_pass", {25'd0, regs_read, regs_write, regs_addr}, {25'd0, 1'b1, 1'b0, 6'h2A});
    host_read = 1'b0;
    // Immediate full update
    request(16'h1234, 16'h0400, 16'h0800, 3'b111, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk_wr($sformatf("imm_wr%0d", i), full_a[i], full_d[i]);
      if (i < 5) tick;
    end
    finish_upd("imm");
    // Masked update: compare1 only
    request(16'hFFFF, 16'hABCD, 16'hEEEE, 3'b010, 1'b0);
    chk_wr("mask_wr0", 6'h03, 8'hCD);
    tick;
    chk_wr("mask_wr1", 6'h04, 8'hAB);
    finish_upd("mask");
    // Synced update on counter reaching zero
    cnt_en = 1'b1; counter_val = 16'd5;
    request(16'h0102, 16'h0, 16'h0, 3'b001, 1'b1);
    chk("sync_wait5", {30'd0, regs_write, busy}, {30'd0, 1'b0, 1'b1});
    for (int v = 4; v >= 0; v--) begin
      tick;
      counter_val = 16'(v);
      #1 chk($sformatf("sync_wait%0d", v), {30'd0, regs_write, busy}, {30'd0, 1'b0, 1'b1});
    end
    tick;
    counter_val = 16'hFFFF;
    chk_wr("sync_wr0", 6'h00, 8'h02);
    tick;
    chk_wr("sync_wr1", 6'h01, 8'h01);
    chk("sync_no_timeout", {31'd0, sync_timeout}, 32'd0);
    finish_upd("sync");
    // Timeout: counter never reaches zero
    counter_val = 16'h0010;
    request(16'h0, 16'h0, 16'h5566, 3'b100, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_wait%0d", i), {30'd0, regs_write, busy}, {30'd0, 1'b0, 1'b1});
      tick;
    end
    chk_wr("to_wr0", 6'h05, 8'h66);
    chk("to_flag", {31'd0, sync_timeout}, 32'd1);
    tick;
    chk_wr("to_wr1", 6'h06, 8'h55);
    finish_upd("to");
    chk("to_sticky", {31'd0, sync_timeout}, 32'd1);
    // Host write stalls the engine's second byte
    cnt_en = 1'b0;
    request(16'h1234, 16'h0400, 16'h0800, 3'b111, 1'b0);
    chk("host_to_clear", {31'd0, sync_timeout}, 32'd0);
    chk_wr("host_wr0", 6'h00, 8'h34);
    tick;
    host_write = 1'b1; host_addr = 6'h02; host_wdata = 8'h01;
    #1 chk_wr("host_cycle", 6'h02, 8'h01);
    tick;
    host_write = 1'b0;
    for (int i = 1; i < 6; i++) begin
      #1 chk_wr($sformatf("host_retry%0d", i), full_a[i], full_d[i]);
      if (i < 5) tick;
    end
    finish_upd("host");
    // Reset in the middle of an update
    request(16'h1234, 16'h0400, 16'h0800, 3'b111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_wr($sformatf("rst_wr%0d", i), full_a[i], full_d[i]);
      tick;
    end
    rst_n = 1'b0;
    #1 chk("rst_mid", {29'd0, regs_write, upd_ready, busy}, {29'd0, 3'b010});
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("rst_after%0d", i), {30'd0, regs_write, busy}, 32'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
